fir_stream: RTL and testbench



---
 rtl/fir_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_fir_stream.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream.sv
// fir_stream: streaming FIR filter with a TAPS-deep sample delay line and a
// TAPS-deep coefficient shift register. Each accepted sample produces one dot
// product, computed on LANES parallel multipliers over G = TAPS/LANES passes
// through a three-stage product / lane-sum / accumulate pipeline.
// Build option: define FIR_SIGNED_EN for two's-complement arithmetic with an
// output saturated to DW bits; otherwise arithmetic is unsigned and the output
// is the low DW bits of the accumulator.
module fir_stream #(
    parameter int DW    = 16,
    parameter int TAPS  = 16,
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_we,
    input  logic [DW-1:0] coef_data,
    input  logic          smp_valid,
    output logic          smp_ready,
    input  logic [DW-1:0] smp_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    localparam int G    = TAPS / LANES;
    localparam int ACCW = 2 * DW + $clog2(TAPS);
    localparam int PW   = 2 * DW;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // The last group leaves MAC, then needs one edge each for product,
    // lane sum and accumulate before the output register can capture it.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

`ifdef FIR_SIGNED_EN
    // Two's-complement product of one sample and one coefficient.
    function automatic logic [PW-1:0] f_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [PW-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    // Sign-extend a product to accumulator width.
    function automatic logic [ACCW-1:0] f_ext(input logic [PW-1:0] p);
        return {{(ACCW-PW){p[PW-1]}}, p};
    endfunction

    // Saturate the accumulator into the signed DW-bit output range.
    function automatic logic [DW-1:0] f_out(input logic [ACCW-1:0] acc);
        logic [ACCW-DW:0] top;
        top = acc[ACCW-1:DW-1];
        if ((top == '0) || (top == '1)) begin
            return acc[DW-1:0];
        end else if (acc[ACCW-1]) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return {1'b0, {(DW-1){1'b1}}};
        end
    endfunction
`else
    // Unsigned product of one sample and one coefficient.
    function automatic logic [PW-1:0] f_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    // Zero-extend a product to accumulator width.
    function automatic logic [ACCW-1:0] f_ext(input logic [PW-1:0] p);
        return {{(ACCW-PW){1'b0}}, p};
    endfunction

    // Output wraps: keep only the low DW bits of the accumulator.
    function automatic logic [DW-1:0] f_out(input logic [ACCW-1:0] acc);
        return acc[DW-1:0];
    endfunction
`endif

    logic [1:0]      r_state;
    logic [GW-1:0]   r_grp;
    logic [1:0]      r_drain;
    logic [DW-1:0]   r_d    [TAPS];
    logic [DW-1:0]   r_coef [TAPS];
    logic [PW-1:0]   r_prod [LANES];
    logic            r_prod_vld;
    logic            r_prod_first;
    logic [ACCW-1:0] r_sum;
    logic            r_sum_vld;
    logic            r_sum_first;
    logic [ACCW-1:0] r_acc;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;

    logic            w_idle;
    logic [PW-1:0]   w_prod [LANES];
    logic [ACCW-1:0] w_sum;

    assign w_idle    = (r_state == ST_IDLE);
    assign smp_ready = w_idle;
    assign busy      = ~w_idle;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Multiply the taps of the group currently being issued.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx       = int'(r_grp) * LANES + l;
            w_prod[l] = f_mul(r_d[idx], r_coef[idx]);
        end
    end

    // Adder tree over the registered lane products.
    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum + f_ext(r_prod[l]);
        end
    end

    // Sample delay line and coefficient shift register; both only move in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_d[i]    <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            if (w_idle && coef_we) begin
                r_coef[0] <= coef_data;
                for (int i = 1; i < TAPS; i++) begin
                    r_coef[i] <= r_coef[i-1];
                end
            end
            if (w_idle && smp_valid) begin
                r_d[0] <= smp_data;
                for (int i = 1; i < TAPS; i++) begin
                    r_d[i] <= r_d[i-1];
                end
            end
        end
    end

    // Control FSM: accept, issue groups, wait for the pipeline, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grp       <= '0;
            r_drain     <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_grp <= '0;
                    if (smp_valid) begin
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_grp == GW'(G - 1)) begin
                        r_grp   <= '0;
                        r_drain <= 2'd0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_out_data  <= f_out(r_acc);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Three-stage datapath: lane products, lane sum, accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                r_prod[l] <= '0;
            end
            r_prod_vld   <= 1'b0;
            r_prod_first <= 1'b0;
            r_sum        <= '0;
            r_sum_vld    <= 1'b0;
            r_sum_first  <= 1'b0;
            r_acc        <= '0;
        end else begin
            r_prod_vld   <= (r_state == ST_MAC);
            r_prod_first <= (r_state == ST_MAC) && (r_grp == '0);
            if (r_state == ST_MAC) begin
                for (int l = 0; l < LANES; l++) begin
                    r_prod[l] <= w_prod[l];
                end
            end
            r_sum_vld   <= r_prod_vld;
            r_sum_first <= r_prod_first;
            if (r_prod_vld) begin
                r_sum <= w_sum;
            end
            if (r_sum_vld) begin
                r_acc <= r_sum_first ? r_sum : (r_acc + r_sum);
            end
        end
    end

endmodule

// File: tb/tb_fir_stream.sv
// Self-checking bench for fir_stream (default parameters DW=16, TAPS=16,
// LANES=4). A plain array model of the delay line and coefficients computes
// the expected dot product for each accepted sample.
module tb_fir_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_we;
    logic [15:0] coef_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_d [16];
    logic [15:0] m_w [16];

    fir_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_we   (coef_we),
        .coef_data (coef_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_y();
`ifdef FIR_SIGNED_EN
        longint acc;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += longint'($signed(m_d[i])) * longint'($signed(m_w[i]));
        end
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
`else
        longint unsigned acc;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            acc += longint'(m_d[i]) * longint'(m_w[i]);
        end
        return acc[15:0];
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_d[i] = 16'h0000;
            m_w[i] = 16'h0000;
        end
    endtask

    task automatic model_shift_d(input logic [15:0] s);
        for (int i = 15; i > 0; i--) m_d[i] = m_d[i-1];
        m_d[0] = s;
    endtask

    task automatic model_shift_w(input logic [15:0] c);
        for (int i = 15; i > 0; i--) m_w[i] = m_w[i-1];
        m_w[0] = c;
    endtask

    task automatic write_coef(input logic [15:0] c);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_data = c;
        @(negedge clk);
        coef_we = 1'b0;
        model_shift_w(c);
    endtask

    // Offer one sample in IDLE (optionally with a same-cycle coefficient write).
    task automatic accept(input logic [15:0] s, input bit wc, input logic [15:0] c);
        @(negedge clk);
        checks++;
        if (smp_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_in_idle: smp_ready=%b expected 1", smp_ready);
        end
        smp_valid = 1'b1;
        smp_data  = s;
        if (wc) begin
            coef_we   = 1'b1;
            coef_data = c;
        end
        @(negedge clk);
        smp_valid = 1'b0;
        coef_we   = 1'b0;
        model_shift_d(s);
        if (wc) model_shift_w(c);
        checks++;
        if ((busy !== 1'b1) || (smp_ready !== 1'b0)) begin
            failures++;
            $display("FAIL busy_after_accept: busy=%b smp_ready=%b expected 1/0", busy, smp_ready);
        end
    endtask

    // Called on the first negedge after acceptance; checks latency and value.
    task automatic wait_result(input string tag, output logic [15:0] got);
        int lat;
        logic [15:0] exp;
        lat = 0;
        while ((out_valid !== 1'b1) && (lat < 40)) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 7) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles expected 7", tag, lat);
        end
        exp = model_y();
        got = out_data;
        checks++;
        if (out_data !== exp) begin
            failures++;
            $display("FAIL %s_data: got %h expected %h", tag, out_data, exp);
        end
    endtask

    // Full transaction with out_ready high: accept, check result, check release.
    task automatic run_sample(input string tag, input logic [15:0] s, input bit wc,
                              input logic [15:0] c, output logic [15:0] got);
        accept(s, wc, c);
        wait_result(tag, got);
        @(negedge clk);
        checks++;
        if ((out_valid !== 1'b0) || (smp_ready !== 1'b1) || (busy !== 1'b0)) begin
            failures++;
            $display("FAIL %s_release: out_valid=%b smp_ready=%b busy=%b expected 0/1/0",
                     tag, out_valid, smp_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        coef_we   = 1'b0;
        coef_data = 16'h0000;
        smp_valid = 1'b0;
        smp_data  = 16'h0000;
        out_ready = 1'b1;
        model_clear();
        #2;
        checks++;
        if ((out_valid !== 1'b0) || (out_data !== 16'h0000) || (busy !== 1'b0) || (smp_ready !== 1'b1)) begin
            failures++;
            $display("FAIL reset_values: out_valid=%b out_data=%h busy=%b smp_ready=%b expected 0/0000/0/1",
                     out_valid, out_data, busy, smp_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        logic [15:0] got;
        for (int i = 0; i < 16; i++) write_coef(16'd1);
        for (int i = 1; i <= 16; i++) run_sample("ramp", 16'(i), 1'b0, 16'h0000, got);
        checks++;
        if (got !== 16'd136) begin
            failures++;
            $display("FAIL ramp_final: got %0d expected 136", got);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] got;
        for (int i = 0; i < 16; i++) run_sample("flush", 16'h0000, 1'b0, 16'h0000, got);
        for (int i = 1; i <= 16; i++) write_coef(16'(i));
        for (int k = 0; k < 16; k++) begin
            run_sample("impulse", (k == 0) ? 16'd1 : 16'd0, 1'b0, 16'h0000, got);
            checks++;
            if (got !== 16'(16 - k)) begin
                failures++;
                $display("FAIL impulse_tap: got %0d expected %0d", got, 16 - k);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        logic [15:0] got;
        out_ready = 1'b0;
        accept(16'($urandom), 1'b0, 16'h0000);
        wait_result("bp", held);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            smp_valid = 1'b1;
            smp_data  = 16'($urandom);
            coef_we   = 1'($urandom_range(0, 1));
            coef_data = 16'($urandom);
            checks++;
            if ((out_valid !== 1'b1) || (out_data !== held) || (smp_ready !== 1'b0)) begin
                failures++;
                $display("FAIL bp_hold: out_valid=%b out_data=%h smp_ready=%b expected 1/%h/0",
                         out_valid, out_data, smp_ready, held);
            end
        end
        @(negedge clk);
        smp_valid = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ((out_valid !== 1'b0) || (smp_ready !== 1'b1)) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b smp_ready=%b expected 0/1", out_valid, smp_ready);
        end
        run_sample("bp_next", 16'($urandom), 1'b0, 16'h0000, got);
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [15:0] got;
        accept(16'h1234, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ((out_valid !== 1'b0) || (out_data !== 16'h0000) || (busy !== 1'b0) || (smp_ready !== 1'b1)) begin
            failures++;
            $display("FAIL reset_mid: out_valid=%b out_data=%h busy=%b smp_ready=%b expected 0/0000/0/1",
                     out_valid, out_data, busy, smp_ready);
        end
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_stale: out_valid high for %0d cycles expected 0", seen);
        end
        for (int i = 0; i < 3; i++) write_coef(16'($urandom_range(1, 255)));
        for (int i = 0; i < 3; i++) run_sample("post_reset", 16'($urandom_range(1, 255)), 1'b0, 16'h0000, got);
    endtask

    task automatic test_overflow();
        logic [15:0] got;
        for (int i = 0; i < 16; i++) write_coef(16'h7FFF);
        for (int i = 0; i < 16; i++) run_sample("ovf_pos", 16'h7FFF, 1'b0, 16'h0000, got);
        checks++;
`ifdef FIR_SIGNED_EN
        if (got !== 16'h7FFF) begin
            failures++;
            $display("FAIL ovf_pos_const: got %h expected 7fff", got);
        end
`else
        if (got !== 16'h0010) begin
            failures++;
            $display("FAIL ovf_pos_const: got %h expected 0010", got);
        end
`endif
        for (int i = 0; i < 16; i++) write_coef(16'h8000);
        run_sample("ovf_neg", 16'h7FFF, 1'b0, 16'h0000, got);
        checks++;
`ifdef FIR_SIGNED_EN
        if (got !== 16'h8000) begin
            failures++;
            $display("FAIL ovf_neg_const: got %h expected 8000", got);
        end
`else
        if (got !== 16'h0000) begin
            failures++;
            $display("FAIL ovf_neg_const: got %h expected 0000", got);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] got;
        for (int i = 0; i < 16; i++) write_coef(16'($urandom));
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) write_coef(16'($urandom));
            run_sample("random", 16'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom), got);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_impulse();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
